// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: phase sequencer for the dino game (IDLE -> RUNNING ->
// CRASHED -> OVER -> RUNNING ...). Paced by the 60 Hz game tick; reacts to
// the debounced start button and the renderer's collision flag.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   game_tick          one-clk pulse per game frame
//   start_btn          debounced start/jump button (level)
//   crash              collision flag (level)
//   run_en             high while RUNNING
//   freeze             high while CRASHED
//   obstacle_speed     obstacle scroll speed, pixels per tick
//   game_start_pulse   one-clk pulse on entry to RUNNING
//   game_over_pulse    one-clk pulse on entry to CRASHED
//   state              IDLE=0, RUNNING=1, CRASHED=2, OVER=3
module game_flow_ctrl #(
   parameter int unsigned SPEED_STEP_TICKS = 600,
   parameter int unsigned MAX_SPEED        = 7,
   parameter int unsigned FREEZE_TICKS     = 60,
   parameter int unsigned RESTART_LOCKOUT  = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       game_tick,
   input  logic       start_btn,
   input  logic       crash,
   output logic       run_en,
   output logic       freeze,
   output logic [2:0] obstacle_speed,
   output logic       game_start_pulse,
   output logic       game_over_pulse,
   output logic [1:0] state
);

   localparam int unsigned MAX_A   = (SPEED_STEP_TICKS > FREEZE_TICKS) ? SPEED_STEP_TICKS : FREEZE_TICKS;
   localparam int unsigned MAX_CNT = (MAX_A > RESTART_LOCKOUT) ? MAX_A : RESTART_LOCKOUT;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

   localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(SPEED_STEP_TICKS - 1);
   localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(FREEZE_TICKS - 1);
   localparam logic [CNT_W-1:0] LOCKOUT     = CNT_W'(RESTART_LOCKOUT);
   localparam logic [2:0]       SPEED_MAX   = 3'(MAX_SPEED);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_CRASHED = 2'd2,
      ST_OVER    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]       speed_d;
   logic             start_q;
   logic             start_rise_q;
   logic             start_pulse_d, over_pulse_d;
   logic             run_en_d, freeze_d;

   assign state = state_q;

   // Registers; start_q resets high so a button held through reset is not a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         tick_cnt_q       <= '0;
         obstacle_speed   <= 3'd0;
         start_q          <= 1'b1;
         start_rise_q     <= 1'b0;
         run_en           <= 1'b0;
         freeze           <= 1'b0;
         game_start_pulse <= 1'b0;
         game_over_pulse  <= 1'b0;
      end else begin
         state_q          <= state_d;
         tick_cnt_q       <= tick_cnt_d;
         obstacle_speed   <= speed_d;
         start_q          <= start_btn;
         start_rise_q     <= start_btn & ~start_q;
         run_en           <= run_en_d;
         freeze           <= freeze_d;
         game_start_pulse <= start_pulse_d;
         game_over_pulse  <= over_pulse_d;
      end
   end

   // Next-state, counter, speed and pulse logic.
   always_comb begin
      state_d       = state_q;
      tick_cnt_d    = tick_cnt_q;
      speed_d       = obstacle_speed;
      start_pulse_d = 1'b0;
      over_pulse_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_rise_q) begin
               state_d       = ST_RUNNING;
               tick_cnt_d    = '0;
               speed_d       = 3'd1;
               start_pulse_d = 1'b1;
            end
         end
         ST_RUNNING: begin
            // Crash pre-empts any speed step on the same cycle.
            if (crash) begin
               state_d      = ST_CRASHED;
               tick_cnt_d   = '0;
               over_pulse_d = 1'b1;
            end else if (game_tick) begin
               if (tick_cnt_q == STEP_LAST) begin
                  tick_cnt_d = '0;
                  if (obstacle_speed < SPEED_MAX) begin
                     speed_d = obstacle_speed + 3'd1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_CRASHED: begin
            if (game_tick) begin
               if (tick_cnt_q == FREEZE_LAST) begin
                  state_d    = ST_OVER;
                  tick_cnt_d = '0;
               end else begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_OVER: begin
            // Start beats a simultaneous tick once the lockout has expired.
            if (start_rise_q && (tick_cnt_q == LOCKOUT)) begin
               state_d       = ST_RUNNING;
               tick_cnt_d    = '0;
               speed_d       = 3'd1;
               start_pulse_d = 1'b1;
            end else if (game_tick && (tick_cnt_q != LOCKOUT)) begin
               tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
         end
      endcase

      run_en_d = (state_d == ST_RUNNING);
      freeze_d = (state_d == ST_CRASHED);
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl: directed scenarios plus a randomized run
// checked against a phase-level reference model.
module tb_game_flow_ctrl;

   localparam int unsigned STEP = 4;
   localparam int unsigned MAXS = 3;
   localparam int unsigned FRZ  = 3;
   localparam int unsigned LOCK = 2;

   logic       clk;
   logic       rst_n;
   logic       game_tick;
   logic       start_btn;
   logic       crash;
   logic       run_en;
   logic       freeze;
   logic [2:0] obstacle_speed;
   logic       game_start_pulse;
   logic       game_over_pulse;
   logic [1:0] state;

   int n_tests = 0;
   int n_fail  = 0;
   int phase   = 0;
   bit last_tick;

   // Reference model: game phase, ticks spent running / in current phase.
   int m_state, m_run, m_ph, m_speed;
   bit m_btn_prev, m_rise_d, m_sp, m_op;

   game_flow_ctrl #(
      .SPEED_STEP_TICKS (STEP),
      .MAX_SPEED        (MAXS),
      .FREEZE_TICKS     (FRZ),
      .RESTART_LOCKOUT  (LOCK)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .game_tick        (game_tick),
      .start_btn        (start_btn),
      .crash            (crash),
      .run_en           (run_en),
      .freeze           (freeze),
      .obstacle_speed   (obstacle_speed),
      .game_start_pulse (game_start_pulse),
      .game_over_pulse  (game_over_pulse),
      .state            (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_state = 0; m_run = 0; m_ph = 0; m_speed = 0;
      m_btn_prev = 1'b1; m_rise_d = 1'b0; m_sp = 1'b0; m_op = 1'b0;
   endtask

   // Advance the model over one clock edge using the inputs currently driven.
   task automatic model_edge();
      bit rise_now;
      rise_now = m_rise_d;
      m_sp = 1'b0;
      m_op = 1'b0;
      case (m_state)
         0: if (rise_now) begin m_state = 1; m_run = 0; m_speed = 1; m_sp = 1'b1; end
         1: begin
            if (crash) begin
               m_state = 2; m_ph = 0; m_op = 1'b1;
            end else if (game_tick) begin
               m_run++;
               m_speed = (1 + m_run / STEP > MAXS) ? MAXS : 1 + m_run / STEP;
            end
         end
         2: if (game_tick) begin
            m_ph++;
            if (m_ph == FRZ) begin m_state = 3; m_ph = 0; end
         end
         default: begin
            if (rise_now && m_ph >= LOCK) begin
               m_state = 1; m_run = 0; m_speed = 1; m_sp = 1'b1;
            end else if (game_tick) begin
               m_ph++;
            end
         end
      endcase
      m_rise_d   = start_btn && !m_btn_prev;
      m_btn_prev = start_btn;
   endtask

   // One clock: tick every 10th call, update model, sample 1 time unit after the edge.
   task automatic step();
      game_tick = (phase == 9);
      last_tick = (phase == 9);
      phase     = (phase + 1) % 10;
      model_edge();
      @(posedge clk);
      #1;
      game_tick = 1'b0;
   endtask

   task automatic do_reset(input logic btn);
      rst_n = 1'b0; crash = 1'b0; game_tick = 1'b0; start_btn = btn;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      phase = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; crash = 1'b0; game_tick = 1'b0; start_btn = 1'b0;
      #2;
      n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
      n_tests++; if (run_en !== 1'b0) begin n_fail++; $display("FAIL reset_run_en: got %0b want 0", run_en); end
      n_tests++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL reset_freeze: got %0b want 0", freeze); end
      n_tests++; if (obstacle_speed !== 3'd0) begin n_fail++; $display("FAIL reset_speed: got %0d want 0", obstacle_speed); end
      n_tests++; if ({game_start_pulse, game_over_pulse} !== 2'b00) begin n_fail++;
         $display("FAIL reset_pulses: got %b want 00", {game_start_pulse, game_over_pulse}); end
   endtask

   task automatic test_start();
      do_reset(1'b1);
      repeat (15) step();
      n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL held_btn_idle: got %0d want 0", state); end
      start_btn = 1'b0;
      repeat (2) step();
      start_btn = 1'b1; phase = 0;
      step();
      n_tests++; if (game_start_pulse !== 1'b0) begin n_fail++; $display("FAIL start_pulse_early: got %0b want 0", game_start_pulse); end
      step();
      n_tests++; if (game_start_pulse !== 1'b1) begin n_fail++; $display("FAIL start_pulse: got %0b want 1", game_start_pulse); end
      n_tests++; if (state !== 2'd1 || run_en !== 1'b1) begin n_fail++;
         $display("FAIL start_state: got state %0d run_en %0b want 1/1", state, run_en); end
      n_tests++; if (obstacle_speed !== 3'd1) begin n_fail++; $display("FAIL start_speed: got %0d want 1", obstacle_speed); end
      step();
      n_tests++; if (game_start_pulse !== 1'b0) begin n_fail++; $display("FAIL start_pulse_width: got %0b want 0", game_start_pulse); end
   endtask

   task automatic test_speed_ramp();
      int k;
      int exp_spd;
      k = 0;
      while (k < 12) begin
         step();
         if (last_tick) begin
            k++;
            exp_spd = (k < 4) ? 1 : (k < 8) ? 2 : 3;
            n_tests++; if (obstacle_speed !== 3'(exp_spd)) begin n_fail++;
               $display("FAIL speed_after_tick%0d: got %0d want %0d", k, obstacle_speed, exp_spd); end
         end
      end
   endtask

   task automatic test_crash_freeze();
      int k;
      repeat (3) step();
      crash = 1'b1;
      step();
      crash = 1'b0;
      n_tests++; if (game_over_pulse !== 1'b1) begin n_fail++; $display("FAIL over_pulse: got %0b want 1", game_over_pulse); end
      n_tests++; if (state !== 2'd2 || freeze !== 1'b1 || run_en !== 1'b0) begin n_fail++;
         $display("FAIL crash_state: got state %0d freeze %0b run_en %0b want 2/1/0", state, freeze, run_en); end
      n_tests++; if (obstacle_speed !== 3'd3) begin n_fail++; $display("FAIL crash_speed_hold: got %0d want 3", obstacle_speed); end
      crash = 1'b1; start_btn = 1'b0;
      step(); step();
      crash = 1'b0;
      n_tests++; if (game_over_pulse !== 1'b0 || state !== 2'd2) begin n_fail++;
         $display("FAIL crash_ignored: got pulse %0b state %0d want 0/2", game_over_pulse, state); end
      k = 0;
      while (k < 3) begin
         step();
         if (last_tick) begin
            k++;
            n_tests++; if (state !== ((k < 3) ? 2'd2 : 2'd3) || freeze !== (k < 3)) begin n_fail++;
               $display("FAIL freeze_tick%0d: got state %0d freeze %0b", k, state, freeze); end
         end
      end
   endtask

   task automatic test_restart_lockout();
      int pulses;
      while (!last_tick) step();
      do step(); while (!last_tick);
      start_btn = 1'b1;
      repeat (3) step();
      n_tests++; if (state !== 2'd3) begin n_fail++; $display("FAIL early_press: got state %0d want 3", state); end
      do step(); while (!last_tick);
      repeat (5) step();
      n_tests++; if (state !== 2'd3) begin n_fail++; $display("FAIL held_across_lockout: got state %0d want 3", state); end
      start_btn = 1'b0;
      repeat (2) step();
      start_btn = 1'b1; phase = 0;
      step();
      pulses = game_start_pulse ? 1 : 0;
      step();
      n_tests++; if (state !== 2'd1 || obstacle_speed !== 3'd1) begin n_fail++;
         $display("FAIL restart: got state %0d speed %0d want 1/1", state, obstacle_speed); end
      for (int i = 0; i < 5; i++) begin
         if (game_start_pulse) pulses++;
         step();
      end
      n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL restart_pulse_count: got %0d want 1", pulses); end
   endtask

   task automatic test_crash_on_step();
      int t;
      t = 0;
      while (t < 3) begin
         step();
         if (last_tick) t++;
      end
      while (phase != 9) step();
      crash = 1'b1;
      step();
      crash = 1'b0;
      n_tests++; if (state !== 2'd2 || obstacle_speed !== 3'd1) begin n_fail++;
         $display("FAIL crash_vs_step: got state %0d speed %0d want 2/1", state, obstacle_speed); end
   endtask

   task automatic test_async_reset();
      int t;
      int pulses;
      do_reset(1'b0);
      step();
      start_btn = 1'b1; phase = 0;
      step(); step();
      t = 0;
      while (t < 4) begin
         step();
         if (last_tick) t++;
      end
      n_tests++; if (obstacle_speed !== 3'd2) begin n_fail++; $display("FAIL pre_reset_speed: got %0d want 2", obstacle_speed); end
      #3;
      rst_n = 1'b0;
      #1;
      n_tests++; if (state !== 2'd0 || run_en !== 1'b0 || freeze !== 1'b0 || obstacle_speed !== 3'd0) begin n_fail++;
         $display("FAIL async_reset: got state %0d run_en %0b freeze %0b speed %0d want 0", state, run_en, freeze, obstacle_speed); end
      start_btn = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      phase = 0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (game_start_pulse || game_over_pulse) pulses++;
      end
      n_tests++; if (pulses !== 0 || state !== 2'd0) begin n_fail++;
         $display("FAIL post_reset_quiet: got pulses %0d state %0d want 0/0", pulses, state); end
   endtask

   task automatic test_random();
      do_reset(1'b0);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 11) == 0) start_btn = ~start_btn;
         crash = ($urandom_range(0, 149) == 0);
         step();
         n_tests++;
         if (state !== 2'(m_state) || run_en !== (m_state == 1) || freeze !== (m_state == 2) ||
             obstacle_speed !== 3'(m_speed) || game_start_pulse !== m_sp || game_over_pulse !== m_op) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got st %0d run %0b frz %0b spd %0d sp %0b op %0b want st %0d spd %0d sp %0b op %0b",
                     i, state, run_en, freeze, obstacle_speed, game_start_pulse, game_over_pulse,
                     m_state, m_speed, m_sp, m_op);
         end
      end
      crash = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; game_tick = 1'b0; start_btn = 1'b0; crash = 1'b0;
      last_tick = 1'b0;
      model_reset();
      test_reset();
      test_start();
      test_speed_ramp();
      test_crash_freeze();
      test_restart_lockout();
      test_crash_on_step();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Game-phase sequencer for the dino game. Consumes the 60 Hz game tick, the debounced start button and the renderer's collision flag. Sequences the game through idle, running, crash-freeze and game-over phases. Drives the run enable, obstacle scroll speed and start/over pulses that gate the obstacle, score and audio blocks.

## Interface

Parameters:
- `SPEED_STEP_TICKS`, default 600: game ticks between speed increments while running (10 s at 60 Hz); must be ≥ 2.
- `MAX_SPEED`, default 7: saturation value of `obstacle_speed`; must be 1..7.
- `FREEZE_TICKS`, default 60: game ticks spent frozen after a crash; must be ≥ 1.
- `RESTART_LOCKOUT`, default 30: game ticks in OVER before a restart is accepted; must be ≥ 1.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `game_tick` in 1: one-`clk`-wide pulse at 60 Hz.
- `start_btn` in 1: debounced start/jump button, level.
- `crash` in 1: collision flag from the renderer, level.
- `run_en` out 1: high only in RUNNING.
- `freeze` out 1: high only in CRASHED.
- `obstacle_speed` out 3: pixels per game tick for obstacle scroll.
- `game_start_pulse` out 1: one-`clk` pulse on entry to RUNNING.
- `game_over_pulse` out 1: one-`clk` pulse on entry to CRASHED.
- `state` out 2: IDLE=0, RUNNING=1, CRASHED=2, OVER=3.

## Operation

- All outputs are registered.
- Reset values: `state`=IDLE, `run_en`=0, `freeze`=0, `obstacle_speed`=0, both pulses 0. Internal tick counter is 0 and the button history register is 1.
- Button history reset to 1 means a button held through reset does not start a game.
- Start edge detection:
  - `start_rise = start_btn & ~start_q`, where `start_q` is `start_btn` delayed one `clk`.
  - Edges are detected on every `clk`, not only on ticks.
- One shared tick counter, `tick_cnt`.
  - Width is `$clog2` of the largest count parameter, plus 1.
  - Cleared on every state transition.
  - Increments only on `game_tick`.
- IDLE:
  - On `start_rise` → RUNNING. Load `obstacle_speed`=1, pulse `game_start_pulse`.
  - `crash` is ignored.
- RUNNING:
  - If `crash`=1 on any `clk` → CRASHED. Pulse `game_over_pulse`. `obstacle_speed` holds its value.
  - Else on `game_tick`:
    - If `tick_cnt == SPEED_STEP_TICKS-1`: `tick_cnt` wraps to 0 and `obstacle_speed` increments, saturating at `MAX_SPEED`.
    - Otherwise `tick_cnt` increments.
  - `start_rise` is ignored.
- CRASHED:
  - On `game_tick` with `tick_cnt == FREEZE_TICKS-1` → OVER.
  - `start_rise` and `crash` are ignored.
- OVER:
  - `tick_cnt` counts ticks, saturating at `RESTART_LOCKOUT`.
  - Once `tick_cnt == RESTART_LOCKOUT`, a `start_rise` → RUNNING. `obstacle_speed`=1, pulse `game_start_pulse`.
  - `start_rise` before lockout expiry is discarded. A button held across expiry needs a fresh release and press.
- Simultaneous events:
  - `crash` together with a speed-step tick in RUNNING: crash wins, speed is not incremented.
  - `start_rise` together with `game_tick` in IDLE/OVER: start wins.
- Reset asserted mid-game forces IDLE immediately (asynchronously); no pulse is emitted.

## Timing

- An event sampled at edge N changes `state`/`run_en`/`freeze`/`obstacle_speed` at edge N+1.
- Pulses:
  - Each pulse is high for exactly the one cycle after edge N+1.
  - The pulse is high only in the first cycle of the new state.
  - No pulse occurs without a state change.
- Button press to `game_start_pulse`: 2 `clk`. One cycle for `start_q`, one for the state register.
- Crash to `game_over_pulse`: 1 `clk`.
- Speed change takes effect the cycle after the qualifying `game_tick`. Downstream obstacle logic samples it on its next tick.
- CRASHED lasts exactly `FREEZE_TICKS` game ticks; the transition follows the `FREEZE_TICKS`-th tick counted in CRASHED.

## Test plan

Use `SPEED_STEP_TICKS`=4, `MAX_SPEED`=3, `FREEZE_TICKS`=3, `RESTART_LOCKOUT`=2, with `game_tick` every 10 `clk`.

1. **Reset/start.** Reset, then hold `start_btn`=1 from reset release → stays IDLE. Release, then press → `game_start_pulse` high for 1 cycle, 2 cycles after the press; `state`=1, `run_en`=1, `obstacle_speed`=1.
2. **Speed ramp.** In RUNNING, 12 ticks → speed 2 after tick 4, 3 after tick 8, still 3 after tick 12 (saturated).
3. **Crash/freeze.**
   - `crash` pulse mid-frame → `game_over_pulse` 1 cycle later; `state`=2, `freeze`=1, speed held.
   - After the 3rd tick → `state`=3, `freeze`=0.
   - `crash` and a 4th-tick speed step in the same cycle → CRASHED, speed unchanged.
4. **Restart lockout.**
   - In OVER, press after 1 tick → ignored.
   - Keep the button held past the 2nd tick → still OVER.
   - Release and press → RUNNING, `obstacle_speed`=1, `game_start_pulse` once.
5. **Async reset mid-game.** Assert `rst_n`=0 between clock edges during RUNNING at speed 2 → outputs zero and `state`=0 immediately; no pulses after release.
